uart_rx_fifo: RTL and testbench

Receive-side byte buffer directly downstream of the uart receiver. Captures each byte the receiver strobes out (recv_req pulse plus data), discards framing-errored bytes, and queues good ones in a show-ahead FIFO for the host. Reports overrun, counts framing errors, and raises a character-idle timeout so the host can drain partial packets without polling.

---
 rtl/uart_rx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer that sits directly behind the uart receiver.
// Good bytes are queued in a show-ahead FIFO. Bytes with a framing error
// are discarded and counted. A byte that arrives while the FIFO is full is
// dropped and sets a sticky overrun flag. A character-idle timeout lets the
// host drain partial packets without polling.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   rx_data_i    received byte, valid only with rx_valid_i
//   rx_valid_i   one-cycle strobe: byte complete
//   rx_ferr_i    framing error for the byte strobed with rx_valid_i
//   rd_en_i      host pop, ignored while empty
//   clr_err_i    one-cycle pulse: clears overrun and ferr_cnt
//   rd_data_o    head entry (show-ahead), 0 when empty
//   empty_o      FIFO holds no entries
//   full_o       FIFO holds DEPTH entries
//   count_o      number of entries held
//   overrun_o    sticky: a good byte was dropped because the FIFO was full
//   ferr_cnt_o   saturating count of discarded framing-error bytes
//   timeout_o    FIFO non-empty and idle for TIMEOUT_BITS bit periods
module uart_rx_fifo #(
  parameter int n            = 8,
  parameter int f_MHz        = 50,
  parameter int f_baud       = 115200,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [n-1:0]               rx_data_i,
  input  logic                       rx_valid_i,
  input  logic                       rx_ferr_i,
  input  logic                       rd_en_i,
  input  logic                       clr_err_i,
  output logic [n-1:0]               rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overrun_o,
  output logic [7:0]                 ferr_cnt_o,
  output logic                       timeout_o
);

  localparam int T_BAUD  = f_MHz * 1000000 / f_baud;
  localparam int TO_CLKS = TIMEOUT_BITS * T_BAUD;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(TO_CLKS + 1);
  localparam logic [CW-1:0] TO_TERM = CW'(TO_CLKS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [n-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    ferr_cnt_q, ferr_cnt_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;

  logic pop;
  logic wr_acc;
  logic ferr_evt;
  logic ovr_evt;
  logic idle_clr;

  assign pop      = rd_en_i & ~empty_q;
  // When full, a same-cycle pop frees the slot the new byte lands in.
  assign wr_acc   = rx_valid_i & ~rx_ferr_i & (~full_q | pop);
  assign ferr_evt = rx_valid_i & rx_ferr_i;
  assign ovr_evt  = rx_valid_i & ~rx_ferr_i & full_q & ~rd_en_i;
  assign idle_clr = wr_acc | pop | empty_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    ferr_cnt_d = ferr_cnt_q;
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_acc, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);

    // A set event in the same cycle as clr_err wins.
    if (clr_err_i) overrun_d = 1'b0;
    if (ovr_evt)   overrun_d = 1'b1;

    if (ferr_evt) begin
      if (clr_err_i)                 ferr_cnt_d = 8'd1;
      else if (ferr_cnt_q != 8'd255) ferr_cnt_d = ferr_cnt_q + 8'd1;
    end else if (clr_err_i) begin
      ferr_cnt_d = 8'd0;
    end

    // Idle counter parks at its terminal value; timeout is flagged on the
    // edge after the counter gets there.
    if (idle_clr) begin
      to_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (to_cnt_q == TO_TERM) begin
      timeout_d = 1'b1;
    end else begin
      to_cnt_d  = to_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_cnt_q <= 8'd0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      ferr_cnt_q <= ferr_cnt_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Storage needs no reset; empty_q masks stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= rx_data_i;
  end

  assign rd_data_o  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign count_o    = count_q;
  assign overrun_o  = overrun_q;
  assign ferr_cnt_o = ferr_cnt_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ferr_i;
  logic       rd_en_i;
  logic       clr_err_i;
  logic [7:0] rd_data_o;
  logic       empty_o;
  logic       full_o;
  logic [2:0] count_o;
  logic       overrun_o;
  logic [7:0] ferr_cnt_o;
  logic       timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fifo #(
    .n(8), .f_MHz(1), .f_baud(100000), .DEPTH(4), .TIMEOUT_BITS(4)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ferr_i(rx_ferr_i),
    .rd_en_i(rd_en_i), .clr_err_i(clr_err_i),
    .rd_data_o(rd_data_o), .empty_o(empty_o), .full_o(full_o),
    .count_o(count_o), .overrun_o(overrun_o), .ferr_cnt_o(ferr_cnt_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d, input logic ferr, input logic rd, input logic clr);
    rx_data_i  = d;
    rx_valid_i = 1'b1;
    rx_ferr_i  = ferr;
    rd_en_i    = rd;
    clr_err_i  = clr;
    tick();
    rx_valid_i = 1'b0;
    rx_ferr_i  = 1'b0;
    rd_en_i    = 1'b0;
    clr_err_i  = 1'b0;
  endtask

  task automatic pop();
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"},   32'(empty_o),    32'd1);
    check({tag, "_full"},    32'(full_o),     32'd0);
    check({tag, "_count"},   32'(count_o),    32'd0);
    check({tag, "_rd_data"}, 32'(rd_data_o),  32'd0);
    check({tag, "_overrun"}, 32'(overrun_o),  32'd0);
    check({tag, "_ferr"},    32'(ferr_cnt_o), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_o),  32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    rst_n_i    = 1'b0;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    rx_ferr_i  = 1'b0;
    rd_en_i    = 1'b0;
    clr_err_i  = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst_n_i = 1'b1;
    tick();

    // 1: basic write / show-ahead / pop
    strobe(8'hA5, 1'b0, 1'b0, 1'b0);
    check("t1_count1", 32'(count_o), 32'd1);
    check("t1_head1", 32'(rd_data_o), 32'hA5);
    strobe(8'h3C, 1'b0, 1'b0, 1'b0);
    check("t1_count2", 32'(count_o), 32'd2);
    check("t1_head2", 32'(rd_data_o), 32'hA5);
    pop();
    check("t1_pop1_data", 32'(rd_data_o), 32'h3C);
    check("t1_pop1_count", 32'(count_o), 32'd1);
    pop();
    check("t1_pop2_empty", 32'(empty_o), 32'd1);
    check("t1_pop2_data", 32'(rd_data_o), 32'd0);
    pop();
    check("t1_pop_empty_count", 32'(count_o), 32'd0);

    // 2: fill, overrun, clr_err, contents intact
    for (int i = 1; i <= 4; i++) strobe(8'(i), 1'b0, 1'b0, 1'b0);
    check("t2_full", 32'(full_o), 32'd1);
    check("t2_count", 32'(count_o), 32'd4);
    strobe(8'h05, 1'b0, 1'b0, 1'b0);
    check("t2_overrun", 32'(overrun_o), 32'd1);
    check("t2_ovr_count", 32'(count_o), 32'd4);
    check("t2_ovr_head", 32'(rd_data_o), 32'h01);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check("t2_clr_overrun", 32'(overrun_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t2_drain%0d", i), 32'(rd_data_o), 32'(i));
      pop();
    end
    check("t2_drained_empty", 32'(empty_o), 32'd1);

    // 3: write + pop while full
    for (int i = 1; i <= 4; i++) strobe(8'(i), 1'b0, 1'b0, 1'b0);
    strobe(8'h05, 1'b0, 1'b1, 1'b0);
    check("t3_overrun", 32'(overrun_o), 32'd0);
    check("t3_count", 32'(count_o), 32'd4);
    check("t3_full", 32'(full_o), 32'd1);
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
    foreach (exp_q[i]) begin
      check($sformatf("t3_drain%0d", i), 32'(rd_data_o), 32'(exp_q[i]));
      pop();
    end
    check("t3_empty", 32'(empty_o), 32'd1);

    // 4: framing errors
    for (int i = 0; i < 3; i++) strobe(8'h77, 1'b1, 1'b0, 1'b0);
    check("t4_ferr3", 32'(ferr_cnt_o), 32'd3);
    check("t4_empty", 32'(empty_o), 32'd1);
    for (int i = 0; i < 260; i++) strobe(8'h77, 1'b1, 1'b0, 1'b0);
    check("t4_ferr_sat", 32'(ferr_cnt_o), 32'd255);
    strobe(8'h77, 1'b1, 1'b0, 1'b1);
    check("t4_clr_set_wins", 32'(ferr_cnt_o), 32'd1);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check("t4_clr", 32'(ferr_cnt_o), 32'd0);
    check("t4_still_empty", 32'(count_o), 32'd0);

    // 5: idle timeout, 40 clocks after the write edge
    strobe(8'h11, 1'b0, 1'b0, 1'b0);
    check("t5_to_at0", 32'(timeout_o), 32'd0);
    for (int i = 1; i <= 39; i++) tick();
    check("t5_to_at39", 32'(timeout_o), 32'd0);
    tick();
    check("t5_to_at40", 32'(timeout_o), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("t5_to_held", 32'(timeout_o), 32'd1);
    pop();
    check("t5_to_cleared", 32'(timeout_o), 32'd0);
    check("t5_empty", 32'(empty_o), 32'd1);
    for (int i = 0; i < 100; i++) tick();
    check("t5_to_stays0", 32'(timeout_o), 32'd0);

    // 6: async reset mid-stream
    strobe(8'h22, 1'b0, 1'b0, 1'b0);
    strobe(8'h33, 1'b0, 1'b0, 1'b0);
    check("t6_pre_count", 32'(count_o), 32'd2);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_state("t6_async");
    tick();
    rst_n_i = 1'b1;
    tick();
    strobe(8'h44, 1'b0, 1'b0, 1'b0);
    check("t6_head", 32'(rd_data_o), 32'h44);
    check("t6_count", 32'(count_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
